// File: rtl/fft_trigger_scanner_pkg.sv
// Shared widths, FSM state codes and the magnitude helper for the trigger FFT scanner.
package fft_trigger_scanner_pkg;

  localparam int unsigned FFT_BINS = 64;
  localparam int unsigned BIN_W    = 6;
  localparam int unsigned DATA_W   = 10;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWaitRdy = 3'd1;
  localparam logic [2:0] StScan    = 3'd2;
  localparam logic [2:0] StDrain   = 3'd3;
  localparam logic [2:0] StDecide  = 3'd4;
  localparam logic [2:0] StHoldoff = 3'd5;

  // |d| of a signed sample; the most negative code saturates to the largest positive one.
  function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] d);
    if (d == {1'b1, {(DATA_W-1){1'b0}}}) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
    if (d[DATA_W-1]) begin
      return ~d + 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/fft_bin_peak_tracker.sv
// Pairs returning RAM data with its bin tag and keeps the running |real| peak of a scan.
module fft_bin_peak_tracker
  import fft_trigger_scanner_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [BIN_W-1:0]  clear_bin,
  input  logic              issue,
  input  logic [BIN_W-1:0]  issue_bin,
  input  logic [DATA_W-1:0] ram_data,
  output logic [BIN_W-1:0]  run_bin,
  output logic [DATA_W-1:0] run_mag
);

  logic [RD_LAT-1:0] vld_q;
  logic [BIN_W-1:0]  tag_q [RD_LAT];
  logic [DATA_W-1:0] mag;

  assign mag = abs_sat(ram_data);

  // Clearing at scan start also flushes tags left over from an aborted scan.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= issue;
      tag_q[0] <= issue_bin;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Strictly-greater update keeps the lowest bin on ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_bin <= '0;
      run_mag <= '0;
    end else if (clear) begin
      run_bin <= clear_bin;
      run_mag <= '0;
    end else if (vld_q[RD_LAT-1] && (mag > run_mag)) begin
      run_bin <= tag_q[RD_LAT-1];
      run_mag <= mag;
    end
  end

endmodule

// File: rtl/fft_trigger_scanner.sv
// Scans a bin band of the trigger FFT output RAM per frame, qualifies peaks over
// consecutive frames and emits a trigger followed by a frame holdoff.
module fft_trigger_scanner
  import fft_trigger_scanner_pkg::*;
#(
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned HIT_COUNT      = 2,
  parameter int unsigned HOLDOFF_FRAMES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_done,
  input  logic              ram_ready,
  input  logic [DATA_W-1:0] ram_data,
  output logic [BIN_W-1:0]  ram_addr,
  input  logic [DATA_W-1:0] threshold,
  input  logic [BIN_W-1:0]  bin_lo,
  input  logic [BIN_W-1:0]  bin_hi,
  output logic              trigger,
  output logic [BIN_W-1:0]  peak_bin,
  output logic [DATA_W-1:0] peak_mag,
  output logic              peak_valid,
  output logic              busy,
  output logic              overrun,
  output logic              scan_abort
);

  logic [2:0]        state_q, state_d;
  logic [BIN_W-1:0]  lo_q, hi_q, addr_q, peak_bin_q, run_bin, start_lo;
  logic [DATA_W-1:0] thr_q, peak_mag_q, run_mag;
  logic [3:0]        hit_cnt_q;
  logic [7:0]        holdoff_q;
  logic [1:0]        drain_q;
  logic              overrun_q, abort_q;
  logic              start, empty, hit, fire, abort, issue, accept;

  assign accept = (state_q == StIdle) && frame_done && enable;
  assign empty  = lo_q > hi_q;
  assign hit    = run_mag >= thr_q;
  assign fire   = (state_q == StDecide) && hit && ((hit_cnt_q + 4'd1) == 4'(HIT_COUNT));
  assign issue  = (state_q == StScan) && !empty && ram_ready;
  assign abort  = (((state_q == StScan) && !empty) || (state_q == StDrain)) && !ram_ready;

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    start_lo = lo_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          start_lo = bin_lo;
          if (ram_ready) begin
            state_d = StScan;
            start   = 1'b1;
          end else begin
            state_d = StWaitRdy;
          end
        end
      end
      StWaitRdy: begin
        if (ram_ready) begin
          state_d = StScan;
          start   = 1'b1;
        end
      end
      StScan: begin
        // An empty band spends a single cycle here without issuing an address.
        if (empty) begin
          state_d = StDecide;
        end else if (!ram_ready) begin
          state_d = StIdle;
        end else if (addr_q == hi_q) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!ram_ready) begin
          state_d = StIdle;
        end else if (drain_q == 2'(RD_LAT - 1)) begin
          state_d = StDecide;
        end
      end
      StDecide: begin
        state_d = (fire && (HOLDOFF_FRAMES > 0)) ? StHoldoff : StIdle;
      end
      StHoldoff: begin
        if (frame_done && (holdoff_q <= 8'd1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      lo_q       <= '0;
      hi_q       <= '0;
      thr_q      <= '0;
      addr_q     <= '0;
      drain_q    <= '0;
      hit_cnt_q  <= '0;
      holdoff_q  <= '0;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
      overrun_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= frame_done && (state_q inside {StWaitRdy, StScan, StDrain, StDecide});
      abort_q   <= abort;
      if (accept) begin
        lo_q  <= bin_lo;
        hi_q  <= bin_hi;
        thr_q <= threshold;
      end
      if (start) begin
        addr_q <= start_lo;
      end else if ((state_q == StScan) && (state_d == StScan)) begin
        addr_q <= addr_q + 1'b1;
      end
      if (state_q == StScan) begin
        drain_q <= '0;
      end else if (state_q == StDrain) begin
        drain_q <= drain_q + 1'b1;
      end
      if (state_q == StDecide) begin
        peak_bin_q <= run_bin;
        peak_mag_q <= run_mag;
        hit_cnt_q  <= (!hit || fire) ? 4'd0 : hit_cnt_q + 4'd1;
        if (fire) begin
          holdoff_q <= 8'(HOLDOFF_FRAMES);
        end
      end else if ((state_q == StHoldoff) && frame_done && (holdoff_q != 8'd0)) begin
        holdoff_q <= holdoff_q - 8'd1;
      end
      // Disabling the scanner breaks any run of consecutive hits.
      if ((state_d == StIdle) && (state_q != StIdle) && !enable) begin
        hit_cnt_q <= '0;
      end
    end
  end

  fft_bin_peak_tracker #(
    .RD_LAT(RD_LAT)
  ) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .clear_bin(start_lo),
    .issue    (issue),
    .issue_bin(addr_q),
    .ram_data (ram_data),
    .run_bin  (run_bin),
    .run_mag  (run_mag)
  );

  // The decision cycle already presents the fresh peak alongside peak_valid.
  assign peak_valid = state_q == StDecide;
  assign trigger    = fire;
  assign busy       = state_q != StIdle;
  assign peak_bin   = peak_valid ? run_bin : peak_bin_q;
  assign peak_mag   = peak_valid ? run_mag : peak_mag_q;
  assign ram_addr   = addr_q;
  assign overrun    = overrun_q;
  assign scan_abort = abort_q;

endmodule

// File: tb/tb_fft_trigger_scanner.sv
// Self-checking bench: fixed vector table, hand-written corner sequences, random frames vs model.
module tb_fft_trigger_scanner;

  localparam int unsigned RD_LAT         = 1;
  localparam int unsigned HIT_COUNT      = 2;
  localparam int unsigned HOLDOFF_FRAMES = 2;

  logic       clk = 1'b0;
  logic       reset, enable, frame_done, ram_ready;
  logic       trigger, peak_valid, busy, overrun, scan_abort;
  logic [9:0] ram_data, threshold, peak_mag;
  logic [5:0] ram_addr, bin_lo, bin_hi, peak_bin;
  logic [9:0] mem [64];

  int n_checks = 0;
  int n_pass   = 0;
  int hits     = 0;

  always #5 clk = ~clk;

  // Output RAM with one cycle of read latency.
  always @(posedge clk) ram_data <= mem[ram_addr];

  fft_trigger_scanner #(
    .RD_LAT        (RD_LAT),
    .HIT_COUNT     (HIT_COUNT),
    .HOLDOFF_FRAMES(HOLDOFF_FRAMES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .frame_done(frame_done),
    .ram_ready (ram_ready),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .threshold (threshold),
    .bin_lo    (bin_lo),
    .bin_hi    (bin_hi),
    .trigger   (trigger),
    .peak_bin  (peak_bin),
    .peak_mag  (peak_mag),
    .peak_valid(peak_valid),
    .busy      (busy),
    .overrun   (overrun),
    .scan_abort(scan_abort)
  );

  typedef struct {
    int lo, hi, thr, b0, v0, b1, v1, e_bin, e_mag, e_cyc;
    bit e_trig;
  } vec_t;
  vec_t tbl [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, exp);
  endtask

  function automatic int abs_of(input logic [9:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) s = -s;
    if (s > 511) s = 511;
    return s;
  endfunction

  function automatic void model_peak(input int lo, input int hi, output int bin, output int mag);
    mag = 0;
    bin = lo;
    for (int b = lo; b <= hi; b++) begin
      if (abs_of(mem[b]) > mag) begin
        mag = abs_of(mem[b]);
        bin = b;
      end
    end
  endfunction

  function automatic int exp_cycle(input int lo, input int hi);
    if (lo > hi) return 2;
    return 1 + (hi - lo + 1) + int'(RD_LAT);
  endfunction

  // Consecutive-hit bookkeeping; returns 1 on the frame that must trigger.
  function automatic bit model_decide(input int mag, input int thr);
    if (mag >= thr) begin
      hits++;
      if (hits == int'(HIT_COUNT)) begin
        hits = 0;
        return 1'b1;
      end
      return 1'b0;
    end
    hits = 0;
    return 1'b0;
  endfunction

  task automatic fill_mem(input int v);
    for (int b = 0; b < 64; b++) mem[b] = 10'(v);
  endtask

  task automatic run_frame(input string tag, input int lo, input int hi, input int thr,
                           input int e_bin, input int e_mag, input int e_cyc, input bit e_trig);
    int pv_cyc, npv, ntrig, got_bin, got_mag;
    pv_cyc = -1; npv = 0; ntrig = 0; got_bin = -1; got_mag = -1;
    bin_lo = 6'(lo); bin_hi = 6'(hi); threshold = 10'(thr);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    if (lo <= hi) check({tag, ".first_addr"}, ram_addr, lo);
    for (int c = 1; c <= e_cyc + 2; c++) begin
      if (c > 1) tick();
      if (peak_valid === 1'b1) begin
        npv++; pv_cyc = c; got_bin = peak_bin; got_mag = peak_mag;
      end
      if (trigger === 1'b1) ntrig++;
    end
    check({tag, ".pv_count"}, npv, 1);
    check({tag, ".pv_cycle"}, pv_cyc, e_cyc);
    check({tag, ".peak_bin"}, got_bin, e_bin);
    check({tag, ".peak_mag"}, got_mag, e_mag);
    check({tag, ".trigger"}, ntrig, e_trig);
    if (e_trig) begin
      check({tag, ".holdoff_busy"}, busy, 1);
      npv = 0;
      for (int f = 0; f < int'(HOLDOFF_FRAMES); f++) begin
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        repeat (4) begin
          if (peak_valid === 1'b1) npv++;
          tick();
        end
      end
      check({tag, ".holdoff_pv"}, npv, 0);
      check({tag, ".holdoff_exit"}, busy, 0);
    end else begin
      check({tag, ".idle"}, busy, 0);
    end
  endtask

  task automatic hand_frame(input string tag, input int lo, input int hi, input int thr,
                            input bit e_trig);
    int b, m;
    model_peak(lo, hi, b, m);
    void'(model_decide(m, thr));
    run_frame(tag, lo, hi, thr, b, m, exp_cycle(lo, hi), e_trig);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int npv, nab, novr, ntrig, pv_cyc, b, m, lo, hi, thr;
    bit t;

    tbl[0] = '{0, 63, 100, 17, 300, -1, 0, 17, 300, 66, 1'b0};
    tbl[1] = '{0, 63, 100, 17, 300, -1, 0, 17, 300, 66, 1'b1};
    tbl[2] = '{0, 15, 100, 5, -512, 9, -512, 5, 511, 18, 1'b0};
    tbl[3] = '{8, 7, 100, -1, 0, -1, 0, 8, 0, 2, 1'b0};
    tbl[4] = '{20, 30, 0, -1, 0, -1, 0, 20, 10, 13, 1'b0};
    tbl[5] = '{3, 3, 50, 3, -50, -1, 0, 3, 50, 3, 1'b1};
    tbl[6] = '{10, 20, 200, 12, 199, 15, -199, 12, 199, 13, 1'b0};
    tbl[7] = '{60, 63, 5, 63, 511, 61, -511, 61, 511, 6, 1'b0};
    tbl[8] = '{0, 0, 10, -1, 0, -1, 0, 0, 10, 3, 1'b1};

    reset = 1'b1; enable = 1'b1; frame_done = 1'b0; ram_ready = 1'b1;
    bin_lo = '0; bin_hi = 6'd63; threshold = '0;
    fill_mem(10);
    repeat (3) tick();
    check("rst.busy", busy, 0);
    check("rst.pulses", {trigger, peak_valid, overrun, scan_abort}, 0);
    check("rst.ram_addr", ram_addr, 0);
    check("rst.peak", {peak_bin, peak_mag}, 0);
    reset = 1'b0;
    tick();
    check("rst.after_busy", busy, 0);

    for (int i = 0; i < 9; i++) begin
      fill_mem(10);
      if (tbl[i].b0 >= 0) mem[tbl[i].b0] = 10'(tbl[i].v0);
      if (tbl[i].b1 >= 0) mem[tbl[i].b1] = 10'(tbl[i].v1);
      run_frame($sformatf("tbl%0d", i), tbl[i].lo, tbl[i].hi, tbl[i].thr,
                tbl[i].e_bin, tbl[i].e_mag, tbl[i].e_cyc, tbl[i].e_trig);
      void'(model_decide(tbl[i].e_mag, tbl[i].thr));
    end

    // Hit, miss, hit, hit: only the fourth triggers; two holdoff frames, then the 7th scans.
    fill_mem(10);
    mem[3] = 10'd200;
    hand_frame("seq.f1", 0, 7, 5, 1'b0);
    hand_frame("seq.f2", 0, 7, 1000, 1'b0);
    hand_frame("seq.f3", 0, 7, 5, 1'b0);
    hand_frame("seq.f4", 0, 7, 5, 1'b1);
    hand_frame("seq.f7", 0, 7, 5, 1'b0);
    hand_frame("seq.f8", 0, 7, 1000, 1'b0);

    // Abort mid-scan keeps the previous peak and the hit count.
    fill_mem(10);
    mem[50] = 10'd300;
    hand_frame("abt.pre", 0, 63, 100, 1'b0);
    bin_lo = 6'd0; bin_hi = 6'd63; threshold = 10'd100;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    npv = 0; nab = 0;
    for (int c = 1; c <= 80; c++) begin
      if (c > 1) tick();
      if (peak_valid === 1'b1) npv++;
      if (scan_abort === 1'b1) nab++;
      if (c == 10) ram_ready = 1'b0;
      if (c == 12) ram_ready = 1'b1;
    end
    check("abt.pulse", nab, 1);
    check("abt.no_pv", npv, 0);
    check("abt.busy", busy, 0);
    check("abt.peak_bin", peak_bin, 50);
    check("abt.peak_mag", peak_mag, 300);
    hand_frame("abt.post", 0, 63, 100, 1'b1);

    // Second frame_done during the scan is flagged and dropped.
    bin_lo = 6'd0; bin_hi = 6'd63; threshold = 10'd1000;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    npv = 0; novr = 0; pv_cyc = -1;
    for (int c = 1; c <= 80; c++) begin
      if (c > 1) tick();
      if (peak_valid === 1'b1) begin
        npv++; pv_cyc = c;
      end
      if (overrun === 1'b1) novr++;
      frame_done = (c == 20);
    end
    frame_done = 1'b0;
    check("ovr.pulse", novr, 1);
    check("ovr.pv_count", npv, 1);
    check("ovr.pv_cycle", pv_cyc, 66);
    model_peak(0, 63, b, m);
    void'(model_decide(m, 1000));

    // Dropping enable mid-scan lets the scan finish but clears the hit run.
    enable = 1'b0;
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick();
    check("en.ignored", busy, 0);
    enable = 1'b1;
    bin_lo = 6'd0; bin_hi = 6'd63; threshold = 10'd100;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    enable = 1'b0;
    npv = 0; ntrig = 0;
    for (int c = 1; c <= 70; c++) begin
      if (c > 1) tick();
      if (peak_valid === 1'b1) npv++;
      if (trigger === 1'b1) ntrig++;
    end
    check("en.pv_count", npv, 1);
    check("en.no_trig", ntrig, 0);
    enable = 1'b1;
    hits = 0;
    hand_frame("en.after", 0, 63, 100, 1'b0);

    // Reset mid-scan, then a frame that waits for ram_ready.
    bin_lo = 6'd0; bin_hi = 6'd63; threshold = 10'd0;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst.busy", busy, 0);
    check("mrst.ram_addr", ram_addr, 0);
    check("mrst.peak", {peak_bin, peak_mag}, 0);
    ntrig = 0; npv = 0;
    for (int c = 0; c < 70; c++) begin
      if ((trigger === 1'b1) || (trigger === 1'bx)) ntrig++;
      if (peak_valid === 1'b1) npv++;
      tick();
    end
    check("mrst.no_trig", ntrig, 0);
    check("mrst.no_pv", npv, 0);
    hits = 0;
    fill_mem(10);
    mem[7] = 10'(-400);
    bin_lo = 6'd4; bin_hi = 6'd20; threshold = 10'd100;
    ram_ready = 1'b0;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("wait.busy", busy, 1);
    npv = 0; pv_cyc = -1; b = -1; m = -1;
    for (int c = 1; c <= 28; c++) begin
      if (c > 1) tick();
      if (c == 6) begin
        check("wait.addr_held", ram_addr, 0);
        ram_ready = 1'b1;
      end
      if (c == 7) check("wait.first_addr", ram_addr, 4);
      if (peak_valid === 1'b1) begin
        npv++; pv_cyc = c; b = peak_bin; m = peak_mag;
      end
    end
    check("wait.pv_count", npv, 1);
    check("wait.pv_cycle", pv_cyc, 25);
    check("wait.peak_bin", b, 7);
    check("wait.peak_mag", m, 400);
    void'(model_decide(400, 100));

    // Random bands, thresholds and RAM contents against the model.
    for (int k = 0; k < 24; k++) begin
      for (int a = 0; a < 64; a++) begin
        mem[a] = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 31) == 0) mem[a] = 10'h200;
      end
      lo = int'($urandom_range(0, 63));
      if (($urandom_range(0, 7) == 0) && (lo > 0)) hi = int'($urandom_range(0, lo - 1));
      else hi = int'($urandom_range(lo, 63));
      thr = int'($urandom_range(0, 600));
      model_peak(lo, hi, b, m);
      t = model_decide(m, thr);
      run_frame($sformatf("rnd%0d", k), lo, hi, thr, b, m, exp_cycle(lo, hi), t);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_trigger_scanner.md
Name: fft_trigger_scanner

Overview:
- Controller for the read port of the trigger FFT's 10x64 output RAM.
- After each FFT frame is written, it walks a configurable bin band and finds the peak |real| bin.
- It counts consecutive frames whose peak meets a threshold, then issues a single-cycle trigger followed by a frame holdoff.
- Sits between the trigger FFT block (address/data/ready of its output RAM) and the capture/sample-record logic that consumes the trigger.

Parameters:
- RD_LAT, 1, RAM read latency in cycles from ram_addr to valid ram_data (legal 1..3).
- HIT_COUNT, 2, consecutive hit frames required to fire trigger (legal 1..15).
- HOLDOFF_FRAMES, 4, frame_done pulses ignored after a trigger (legal 0..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scanner enable, level.
- frame_done  in  1  one-cycle pulse: FFT finished writing a frame to output RAM.
- ram_ready  in  1  high when the output RAM is not being written.
- ram_data  in  10  RAM read data, signed two's complement real part.
- ram_addr  out  6  RAM read address.
- threshold  in  10  unsigned magnitude threshold.
- bin_lo  in  6  first bin of band, inclusive.
- bin_hi  in  6  last bin of band, inclusive.
- trigger  out  1  one-cycle trigger pulse.
- peak_bin  out  6  bin index of the last completed scan's peak.
- peak_mag  out  10  magnitude of the last completed scan's peak.
- peak_valid  out  1  one-cycle pulse; peak_bin/peak_mag updated.
- busy  out  1  high in any state except IDLE.
- overrun  out  1  one-cycle pulse: frame_done arrived while scanning.
- scan_abort  out  1  one-cycle pulse: scan abandoned because ram_ready dropped.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; hit and holdoff counters 0.
- States:
  - IDLE: on frame_done & enable → SCAN if ram_ready, else WAIT_RDY. Latch bin_lo, bin_hi and threshold at this transition.
  - WAIT_RDY: → SCAN on ram_ready. Has no timeout.
  - SCAN: ram_addr steps from latched lo to hi, one address per cycle. After issuing hi → DRAIN.
  - DRAIN: lasts RD_LAT cycles while the last data returns, then → DECIDE.
  - DECIDE: lasts 1 cycle. Pulse peak_valid. Evaluate hit, update hit count, assert trigger if required. Then → HOLDOFF if trigger fired and HOLDOFF_FRAMES>0, else IDLE.
  - HOLDOFF: decrement on each frame_done (frames are not scanned); → IDLE when the count reaches 0.
- Magnitude rule: mag = |ram_data|, and −512 saturates to 511. Running peak updates only on mag strictly greater than the current peak, so ties go to the lowest bin. The running peak resets to mag 0 / bin lo at scan start.
- Data alignment: a valid/bin-tag shift register of depth RD_LAT pairs each returned ram_data with its address. No sample is taken outside the band.
- Hit test: peak_mag ≥ threshold is a hit.
  - Hit: hit_cnt+1. If it reaches HIT_COUNT, trigger=1 and hit_cnt clears.
  - Miss: hit_cnt clears.
- Latency: with frame_done in cycle 0, ram_ready high and N = hi−lo+1 bins, the first address is presented in cycle 1 and DECIDE (peak_valid/trigger) occurs in cycle 1+N+RD_LAT.
- Empty band (bin_lo > bin_hi latched): skip SCAN/DRAIN and go straight to DECIDE with peak_mag 0, peak_bin lo. This counts as a miss unless threshold==0.
- ram_ready low during SCAN or DRAIN: abort. Pulse scan_abort, leave peak outputs unchanged, leave hit_cnt unchanged, → IDLE.
- frame_done while in WAIT_RDY/SCAN/DRAIN/DECIDE: pulse overrun; the frame is ignored.
- enable low: any scan in progress completes. On entering IDLE with enable low, hit_cnt clears. A HOLDOFF in progress still counts down.
- ram_addr holds its last value outside SCAN.
- reset mid-operation: immediate return to reset values the next cycle; no trigger is emitted.

Decomposition:
- Shared package: state enum (IDLE, WAIT_RDY, SCAN, DRAIN, DECIDE, HOLDOFF), FFT_BINS=64, BIN_W=6, DATA_W=10.
- One sub-module, fft_bin_peak_tracker: abs/saturate, strict-greater compare, peak registers, and the RD_LAT valid/tag pipeline. The FSM and counters stay in the top level.

Test Plan:
- Band 0..63, RD_LAT=1, threshold=100, HIT_COUNT=1; RAM bin 17=+300, others 10 → peak_valid and trigger in cycle 66 after frame_done, peak_bin=17, peak_mag=300.
- Ties and saturation: bins 5 and 9 = −512, band 0..15 → peak_mag=511, peak_bin=5. Band 8..7 → DECIDE in cycle 2, peak_mag=0, no trigger (threshold=100).
- Hit sequencing: HIT_COUNT=2, HOLDOFF_FRAMES=2; frames hit, miss, hit, hit → trigger only on frame 4. The next 2 frame_done are ignored (no peak_valid); frame 7 is scanned.
- Abort: drop ram_ready at the 10th SCAN cycle → scan_abort=1, no peak_valid, hit_cnt preserved. The next frame scans normally.
- Overrun: second frame_done 20 cycles after the first (band 0..63) → overrun pulse, exactly one peak_valid.
- Reset mid-SCAN, then frame_done with ram_ready low for 5 cycles → outputs 0 after reset; first address 6 cycles after the WAIT_RDY entry; result correct.
